// File: rtl/ntt_pkg.sv
// Shared types and helpers for the NTT BRAM DMA engine.
package ntt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KICK,
    WAIT,
    UNLOAD,
    DONE
  } state_e;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [31:0] bit_rev(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(w)) r[i] = v[5'(w - 32'(i) - 1)];
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_bram_dma_if.sv
// Valid/ready stream bundle used for the coefficient input and the result output.
interface ntt_bram_dma_if #(
  parameter int unsigned DATA_W = 64
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/ntt_skid_fifo.sv
// Small circular FIFO absorbing BRAM read data so the output can stall without losing beats.
module ntt_skid_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 3
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push_i,
  input  logic [DATA_W-1:0]            data_i,
  input  logic                         pop_i,
  output logic [DATA_W-1:0]            data_o,
  output logic                         valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid_o = (count_q != '0);
  assign count_o = count_q;
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

endmodule

// File: rtl/ntt_bram_dma.sv
// Streams N coefficients into BRAM, kicks the NTT core, then streams the result back out
// (optionally in bit-reversed order) through a skid FIFO sized for the BRAM read latency.
module ntt_bram_dma
  import ntt_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned N      = 4096,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned BASE   = 0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                bitrev,
  output logic                busy,
  output logic                job_done,
  ntt_bram_dma_if.slave       s,
  ntt_bram_dma_if.master      m,
  output logic                ntt_start,
  input  logic                ntt_done,
  output logic                BRAM_clk,
  output logic                BRAM_en,
  output logic                BRAM_we,
  output logic                BRAM_rst,
  output logic [ADDR_W-1:0]   BRAM_addr,
  output logic [DATA_W-1:0]   BRAM_din,
  input  logic [DATA_W-1:0]   BRAM_dout
);
  localparam int unsigned AW    = $clog2(N);
  localparam int unsigned DEPTH = RD_LAT + 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  state_e            state_q;
  logic [AW-1:0]     cnt_q, out_cnt_q, rd_idx;
  logic              rd_all_q, bitrev_q, rst_hold_q;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic              wr_beat, issue, pop, push, fifo_valid;
  logic [CW-1:0]     fifo_cnt;
  logic [DATA_W-1:0] fifo_data;
  int unsigned       occ;

  always_comb begin
    wr_beat = (state_q == LOAD) && s.tvalid;
    pop     = fifo_valid && m.tready;
    push    = pipe_q[RD_LAT-1];
    // Slots already claimed: FIFO contents after this cycle's pop plus reads still in the pipe.
    occ = 32'(fifo_cnt);
    for (int i = 0; i < int'(RD_LAT); i++) occ = occ + 32'(pipe_q[i]);
    if (pop) occ = occ - 1;
    issue  = (state_q == UNLOAD) && !rd_all_q && (occ < DEPTH);
    pipe_d = pipe_q << 1;
    pipe_d[0] = issue;
    rd_idx = bitrev_q ? AW'(bit_rev(32'(cnt_q), AW)) : cnt_q;

    BRAM_en   = wr_beat || issue;
    BRAM_we   = wr_beat;
    BRAM_din  = wr_beat ? s.tdata : '0;
    BRAM_addr = ADDR_W'(BASE);
    if (wr_beat)    BRAM_addr = ADDR_W'(BASE) + ADDR_W'(cnt_q);
    else if (issue) BRAM_addr = ADDR_W'(BASE) + ADDR_W'(rd_idx);
  end

  assign BRAM_clk  = clk;
  assign BRAM_rst  = rst_hold_q;
  assign busy      = (state_q != IDLE);
  assign job_done  = (state_q == DONE);
  assign ntt_start = (state_q == KICK);
  assign s.tready  = (state_q == LOAD);
  assign m.tvalid  = fifo_valid;
  assign m.tdata   = fifo_data;
  assign m.tlast   = fifo_valid && (out_cnt_q == LAST);

  ntt_skid_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .data_i  (BRAM_dout),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .valid_o (fifo_valid),
    .count_o (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      out_cnt_q  <= '0;
      rd_all_q   <= 1'b0;
      bitrev_q   <= 1'b0;
      pipe_q     <= '0;
      rst_hold_q <= 1'b1;
    end else begin
      rst_hold_q <= 1'b0;
      pipe_q     <= pipe_d;
      if (pop) out_cnt_q <= out_cnt_q + AW'(1);
      case (state_q)
        IDLE: if (start) begin
          state_q   <= LOAD;
          bitrev_q  <= bitrev;
          cnt_q     <= '0;
          out_cnt_q <= '0;
          rd_all_q  <= 1'b0;
        end
        LOAD: if (wr_beat) begin
          cnt_q <= cnt_q + AW'(1);
          if (cnt_q == LAST) state_q <= KICK;
        end
        KICK: state_q <= WAIT;
        WAIT: if (ntt_done) state_q <= UNLOAD;
        UNLOAD: begin
          if (issue) begin
            cnt_q <= cnt_q + AW'(1);
            if (cnt_q == LAST) rd_all_q <= 1'b1;
          end
          if (pop && (out_cnt_q == LAST)) state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_bram_dma.sv
// Directed bench for ntt_bram_dma with a BRAM model and a stream-level reference model.
module tb_ntt_bram_dma;
  localparam int DW = 64, AW = 13, N = 8, RD_LAT = 2, BASE = 16, LOGN = 3;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, bitrev = 1'b0, ntt_done = 1'b0;
  logic busy, job_done, ntt_start, BRAM_clk, BRAM_en, BRAM_we, BRAM_rst;
  logic [AW-1:0] BRAM_addr;
  logic [DW-1:0] BRAM_din, BRAM_dout;

  ntt_bram_dma_if #(.DATA_W(DW)) s_if ();
  ntt_bram_dma_if #(.DATA_W(DW)) m_if ();

  ntt_bram_dma #(.DATA_W(DW), .ADDR_W(AW), .N(N), .RD_LAT(RD_LAT), .BASE(BASE)) dut (
    .clk(clk), .rstn(rstn), .start(start), .bitrev(bitrev), .busy(busy), .job_done(job_done),
    .s(s_if), .m(m_if), .ntt_start(ntt_start), .ntt_done(ntt_done), .BRAM_clk(BRAM_clk),
    .BRAM_en(BRAM_en), .BRAM_we(BRAM_we), .BRAM_rst(BRAM_rst), .BRAM_addr(BRAM_addr),
    .BRAM_din(BRAM_din), .BRAM_dout(BRAM_dout)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM with RD_LAT = 2 registered read stages
  logic [DW-1:0] mem [0:8191];
  logic [DW-1:0] rd_s0 = '0, rd_s1 = '0;
  always @(posedge clk) begin
    if (BRAM_en && BRAM_we) mem[BRAM_addr] <= BRAM_din;
    if (BRAM_en && !BRAM_we) rd_s0 <= mem[BRAM_addr];
    rd_s1 <= rd_s0;
  end
  assign BRAM_dout = rd_s1;

  int ready_mode = 0;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic rdy = 1'b1;
  always @(posedge clk) begin
    #1;
    rdy = (ready_mode == 0) ? 1'b1 : pat[cyc % 4];
  end
  assign m_if.tready = rdy;
  assign s_if.tlast  = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: loaded data plus required output order
  logic [DW-1:0] ld [N];
  logic [DW-1:0] got [N];
  logic exp_br = 1'b0;
  int wr_k = 0, out_j = 0, first_vcyc = -1, last_pop_cyc = -1, done_cyc = -1;
  int done_cnt = 0, nstart_cnt = 0, gaps = 0;
  bit stalled = 0;
  logic [DW-1:0] held = '0;

  function automatic int rev(input int j);
    int r = 0;
    int x = j;
    for (int b = 0; b < LOGN; b++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] exp_out(input int j);
    return ld[exp_br ? rev(j) : j];
  endfunction

  always @(negedge clk) begin
    if (rstn) begin
      if (BRAM_en) chk("addr_range", 64'(BRAM_addr >= BASE && BRAM_addr < BASE + N), 1);
      if (BRAM_en && BRAM_we) begin
        if (wr_k < N) begin
          chk("wr_addr", 64'(BRAM_addr), 64'(BASE + wr_k));
          chk("wr_data", BRAM_din, ld[wr_k]);
          chk("wr_handshake", 64'(s_if.tvalid && s_if.tready), 1);
        end else chk("extra_write", 64'(wr_k + 1), N);
        wr_k++;
      end
      if (m_if.tvalid) begin
        if (out_j < N) begin
          chk("out_data", m_if.tdata, exp_out(out_j));
          chk("out_last", 64'(m_if.tlast), 64'(out_j == N - 1));
          if (stalled) chk("stall_hold", m_if.tdata, held);
          if (first_vcyc < 0) first_vcyc = cyc;
          if (m_if.tready) begin
            got[out_j] = m_if.tdata;
            if (out_j == N - 1) last_pop_cyc = cyc;
            out_j++;
            stalled = 0;
          end else begin
            stalled = 1;
            held = m_if.tdata;
          end
        end else chk("extra_beat", 64'(out_j + 1), N);
      end else begin
        chk("tlast_idle", 64'(m_if.tlast), 0);
        if (out_j > 0 && out_j < N) gaps++;
      end
      if (job_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (ntt_start) nstart_cnt++;
    end
  end

  task automatic chk_reset_vals();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_job_done", 64'(job_done), 0);
    chk("rst_s_tready", 64'(s_if.tready), 0);
    chk("rst_m_tvalid", 64'(m_if.tvalid), 0);
    chk("rst_m_tlast", 64'(m_if.tlast), 0);
    chk("rst_ntt_start", 64'(ntt_start), 0);
    chk("rst_bram_en", 64'(BRAM_en), 0);
    chk("rst_bram_we", 64'(BRAM_we), 0);
    chk("rst_bram_addr", 64'(BRAM_addr), BASE);
    chk("rst_bram_din", BRAM_din, 0);
    chk("rst_m_tdata", m_if.tdata, 0);
    chk("rst_bram_rst", 64'(BRAM_rst), 1);
  endtask

  task automatic run_job(input logic br, input int rmode, input bit inject, input int abort_at,
                         input logic [DW-1:0] base, input logic [DW-1:0] mult);
    int x, d0;
    for (int k = 0; k < N; k++) ld[k] = base + 64'(k) * mult;
    exp_br = br; wr_k = 0; out_j = 0; first_vcyc = -1; last_pop_cyc = -1; stalled = 0;
    gaps = 0; nstart_cnt = 0; d0 = done_cnt; ready_mode = rmode;
    @(posedge clk); #1;
    start = 1'b1; bitrev = br;
    @(posedge clk); #1;
    start = 1'b0; bitrev = ~br;
    chk("busy_load", 64'(busy), 1);
    chk("s_tready_load", 64'(s_if.tready), 1);
    for (int k = 0; k < N; k++) begin
      s_if.tvalid = 1'b1; s_if.tdata = ld[k]; ntt_done = inject && (k == 3);
      @(posedge clk); #1;
    end
    s_if.tvalid = 1'b0; s_if.tdata = '0; ntt_done = 1'b0;
    chk("ntt_start_kick", 64'(ntt_start), 1);
    chk("s_tready_kick", 64'(s_if.tready), 0);
    chk("wr_count", 64'(wr_k), N);
    @(posedge clk); #1;
    chk("ntt_start_wait", 64'(ntt_start), 0);
    chk("bram_en_wait", 64'(BRAM_en), 0);
    chk("busy_wait", 64'(busy), 1);
    for (int c = 0; c < 19; c++) begin
      if (inject && c == 5) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("bram_en_wait2", 64'(BRAM_en), 0);
    ntt_done = 1'b1; x = cyc;
    @(posedge clk); #1;
    ntt_done = 1'b0;
    for (int c = 0; c < 300 && done_cnt == d0; c++) begin
      if (abort_at >= 0 && out_j >= abort_at) break;
      @(posedge clk); #1;
    end
    if (abort_at >= 0) begin
      chk("abort_point", 64'(out_j), 64'(abort_at));
      rstn = 1'b0;
      #1;
      chk_reset_vals();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("bram_rst_release", 64'(BRAM_rst), 1);
      @(posedge clk); #1;
      chk("bram_rst_clear", 64'(BRAM_rst), 0);
      repeat (10) @(posedge clk);
      #1;
      chk("no_done_after_abort", 64'(done_cnt), 64'(d0));
      chk("idle_after_abort", 64'(busy), 0);
    end else begin
      chk("job_done_seen", 64'(done_cnt), 64'(d0 + 1));
      chk("beat_count", 64'(out_j), N);
      chk("done_after_last", 64'(done_cyc), 64'(last_pop_cyc + 1));
      chk("ntt_start_count", 64'(nstart_cnt), 1);
      if (rmode == 0) begin
        chk("first_valid_lat", 64'(first_vcyc), 64'(x + 1 + RD_LAT + 1));
        chk("gaps", 64'(gaps), 0);
      end
      repeat (3) @(posedge clk);
      #1;
      chk("busy_idle", 64'(busy), 0);
      chk("single_done", 64'(done_cnt), 64'(d0 + 1));
    end
  endtask

  logic [DW-1:0] lit_lin [N] = '{1, 2, 3, 4, 5, 6, 7, 8};
  logic [DW-1:0] lit_rev [N] = '{1, 5, 3, 7, 2, 6, 4, 8};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("bram_rst_post", 64'(BRAM_rst), 1);
    @(posedge clk); #1;
    chk("bram_rst_low", 64'(BRAM_rst), 0);
    chk("idle_busy", 64'(busy), 0);
    chk("idle_s_tready", 64'(s_if.tready), 0);

    run_job(1'b0, 0, 1'b0, -1, 64'd1, 64'd1);
    for (int k = 0; k < N; k++) chk("order_linear", got[k], lit_lin[k]);
    run_job(1'b1, 0, 1'b0, -1, 64'd1, 64'd1);
    for (int k = 0; k < N; k++) chk("order_bitrev", got[k], lit_rev[k]);
    run_job(1'b0, 1, 1'b0, -1, 64'h100, 64'h111);
    run_job(1'b1, 1, 1'b1, -1, 64'hDEAD_0000, 64'h0001_0003);
    run_job(1'b0, 0, 1'b0, 3, 64'd1, 64'd1);
    run_job(1'b0, 0, 1'b0, -1, 64'hA0, 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
